// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//   Conditions N raw board keys/switches into clean debounced levels plus
//   one-cycle press/release event pulses. Each channel is independent:
//   a 2-flop synchronizer, a polarity normalizer, a saturating stability
//   counter and a 4-state FSM (IDLE / PRESS_PEND / HELD / RELEASE_PEND).
//
//   Optional feature macro: KEY_REPEAT_EN
//     defined   : while a key stays HELD, extra press_o pulses are emitted
//                 REPEAT_DELAY cycles after the accepted press and then every
//                 REPEAT_RATE cycles.
//     undefined : exactly one press_o per accepted press; REPEAT_* ignored.
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  synchronous reset, active-high
//   key_i      in   N  raw asynchronous key inputs
//   key_o      out  N  debounced level, 1 = pressed
//   press_o    out  N  1-cycle pulse on accepted press (and auto-repeat)
//   release_o  out  N  1-cycle pulse on accepted release
// ---------------------------------------------------------------------------
module key_debounce #(
   parameter int N            = 10,
   parameter int DEBOUNCE_CYC = 250000,
   parameter int ACTIVE_LOW   = 1,
   parameter int REPEAT_DELAY = 12500000,
   parameter int REPEAT_RATE  = 2500000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] key_i,
   output logic [N-1:0] key_o,
   output logic [N-1:0] press_o,
   output logic [N-1:0] release_o
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   // Raw level that means "not pressed"; sync flops reset to it so that a key
   // held through reset is seen as a fresh press needing full qualification.
   localparam logic [N-1:0] REL_LVL = {N{(ACTIVE_LOW != 0)}};

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_PEND   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_PEND = 2'd3
   } state_t;

   logic [N-1:0] sync1_q;
   logic [N-1:0] sync2_q;
   logic [N-1:0] s_s;

   // Two-flop synchronizer for the asynchronous key pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= REL_LVL;
         sync2_q <= REL_LVL;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
      end
   end

   // Normalize polarity so that s_s = 1 means pressed.
   assign s_s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

   for (genvar i = 0; i < N; i++) begin : g_ch
      state_t        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [CW-1:0] cnt_inc_s;
      logic          key_q, key_d;
      logic          press_q, press_d;
      logic          rel_q, rel_d;

`ifdef KEY_REPEAT_EN
      localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
      localparam int RW   = $clog2(RMAX + 1);
      logic [RW-1:0] rep_q, rep_d;
      logic          first_q, first_d;
      logic [RW-1:0] rep_last_s;

      // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE.
      assign rep_last_s = first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1);

      // Auto-repeat counter and first/subsequent phase flag.
      always_ff @(posedge clk) begin
         if (rst) begin
            rep_q   <= {RW{1'b0}};
            first_q <= 1'b1;
         end else begin
            rep_q   <= rep_d;
            first_q <= first_d;
         end
      end
`endif

      // Saturating increment; the counter must never wrap.
      assign cnt_inc_s = (cnt_q == CW'(DEBOUNCE_CYC)) ? cnt_q : cnt_q + CW'(1);

      // Per-channel FSM state, stability counter and registered outputs.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            key_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            press_q <= press_d;
            rel_q   <= rel_d;
         end
      end

      // Next-state logic: qualify each level change for DEBOUNCE_CYC cycles.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         key_d   = key_q;
         press_d = 1'b0;
         rel_d   = 1'b0;
`ifdef KEY_REPEAT_EN
         // Any path other than staying in HELD clears the repeat timing.
         rep_d   = {RW{1'b0}};
         first_d = 1'b1;
`endif
         case (state_q)
            ST_IDLE: begin
               key_d = 1'b0;
               if (s_s[i]) begin
                  state_d = ST_PRESS_PEND;
                  cnt_d   = CW'(1);
               end else begin
                  cnt_d   = {CW{1'b0}};
               end
            end
            ST_PRESS_PEND: begin
               if (!s_s[i]) begin
                  state_d = ST_IDLE;
                  cnt_d   = {CW{1'b0}};
               end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                  state_d = ST_HELD;
                  key_d   = 1'b1;
                  press_d = 1'b1;
                  cnt_d   = {CW{1'b0}};
               end else begin
                  cnt_d   = cnt_inc_s;
               end
            end
            ST_HELD: begin
               if (!s_s[i]) begin
                  state_d = ST_RELEASE_PEND;
                  cnt_d   = CW'(1);
               end else begin
                  cnt_d   = {CW{1'b0}};
`ifdef KEY_REPEAT_EN
                  if (rep_q == rep_last_s) begin
                     press_d = 1'b1;
                     rep_d   = {RW{1'b0}};
                     first_d = 1'b0;
                  end else begin
                     rep_d   = rep_q + RW'(1);
                     first_d = first_q;
                  end
`endif
               end
            end
            ST_RELEASE_PEND: begin
               if (s_s[i]) begin
                  state_d = ST_HELD;
                  cnt_d   = {CW{1'b0}};
               end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                  state_d = ST_IDLE;
                  key_d   = 1'b0;
                  rel_d   = 1'b1;
                  cnt_d   = {CW{1'b0}};
               end else begin
                  cnt_d   = cnt_inc_s;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = {CW{1'b0}};
               key_d   = 1'b0;
            end
         endcase
      end

      assign key_o[i]     = key_q;
      assign press_o[i]   = press_q;
      assign release_o[i] = rel_q;
   end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

   localparam int N   = 4;
   localparam int DB  = 4;
   localparam int RD  = 10;
   localparam int RR  = 3;
`ifdef KEY_REPEAT_EN
   localparam bit       REP_EN = 1'b1;
   localparam logic [3:0] REP_P = 4'h8;
`else
   localparam bit       REP_EN = 1'b0;
   localparam logic [3:0] REP_P = 4'h0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] key_i;
   logic [N-1:0] key_o, press_o, release_o;

   key_debounce #(
      .N(N), .DEBOUNCE_CYC(DB), .ACTIVE_LOW(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk(clk), .rst(rst), .key_i(key_i),
      .key_o(key_o), .press_o(press_o), .release_o(release_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] k;
      logic [3:0] p;
      logic [3:0] r;
   } exp_t;

   typedef struct {
      logic       rst;
      logic [3:0] key;
      int         ncyc;
      logic [3:0] ek;
      logic [3:0] ep;
      logic [3:0] er;
   } seg_t;

   exp_t sb_q[$];
   seg_t segs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: level + run-length of consecutive disagreeing samples.
   logic [3:0] m_sync1, m_sync2, m_lvl;
   int         m_run[4];
   int         m_hold[4];

   function automatic exp_t model_step(input logic r, input logic [3:0] k);
      exp_t       e;
      logic [3:0] s;
      e.k = 4'h0; e.p = 4'h0; e.r = 4'h0;
      if (r) begin
         m_sync1 = 4'hF;
         m_sync2 = 4'hF;
         m_lvl   = 4'h0;
         for (int c = 0; c < 4; c++) begin
            m_run[c]  = 0;
            m_hold[c] = 0;
         end
      end else begin
         s = ~m_sync2;
         m_sync2 = m_sync1;
         m_sync1 = k;
         for (int c = 0; c < 4; c++) begin
            if (s[c] != m_lvl[c]) begin
               m_run[c]  = m_run[c] + 1;
               m_hold[c] = 0;
               if (m_run[c] == DB) begin
                  m_lvl[c] = s[c];
                  if (s[c]) e.p[c] = 1'b1;
                  else      e.r[c] = 1'b1;
                  m_run[c] = 0;
               end
            end else begin
               if (m_lvl[c] && m_run[c] == 0) begin
                  m_hold[c] = m_hold[c] + 1;
                  if (REP_EN && (m_hold[c] == RD ||
                      (m_hold[c] > RD && ((m_hold[c] - RD) % RR) == 0)))
                     e.p[c] = 1'b1;
               end else begin
                  m_hold[c] = 0;
               end
               m_run[c] = 0;
            end
         end
         e.k = m_lvl;
      end
      return e;
   endfunction

   task automatic tick(input logic r, input logic [3:0] k);
      exp_t e;
      rst   = r;
      key_i = k;
      sb_q.push_back(model_step(r, k));
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_tests++;
      if (key_o !== e.k || press_o !== e.p || release_o !== e.r ||
          (press_o & release_o) !== 4'h0) begin
         n_fail++;
         $display("FAIL cycle: key_o=%h press_o=%h release_o=%h, required %h %h %h",
                  key_o, press_o, release_o, e.k, e.p, e.r);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] k, input int n,
                      input logic [3:0] ek, input logic [3:0] ep, input logic [3:0] er);
      seg_t sg;
      sg.rst = r; sg.key = k; sg.ncyc = n; sg.ek = ek; sg.ep = ep; sg.er = er;
      segs.push_back(sg);
   endtask

   initial begin
      rst   = 1'b1;
      key_i = 4'hF;
      // reset and idle with all keys released
      add(1'b1, 4'hF, 3,  4'h0, 4'h0, 4'h0);
      add(1'b0, 4'hF, 20, 4'h0, 4'h0, 4'h0);
      // clean press / release on channel 0
      add(1'b0, 4'hE, 6,  4'h1, 4'h1, 4'h0);
      add(1'b0, 4'hE, 5,  4'h1, 4'h0, 4'h0);
      add(1'b0, 4'hF, 6,  4'h0, 4'h0, 4'h1);
      add(1'b0, 4'hF, 2,  4'h0, 4'h0, 4'h0);
      // bounce on channel 1, then a valid press and release
      add(1'b0, 4'hD, 3,  4'h0, 4'h0, 4'h0);
      add(1'b0, 4'hF, 1,  4'h0, 4'h0, 4'h0);
      add(1'b0, 4'hD, 3,  4'h0, 4'h0, 4'h0);
      add(1'b0, 4'hF, 6,  4'h0, 4'h0, 4'h0);
      add(1'b0, 4'hD, 6,  4'h2, 4'h2, 4'h0);
      add(1'b0, 4'hF, 6,  4'h0, 4'h0, 4'h2);
      // simultaneous press/release on all channels
      add(1'b0, 4'h0, 6,  4'hF, 4'hF, 4'h0);
      add(1'b0, 4'hF, 6,  4'h0, 4'h0, 4'hF);
      // reset during PRESS_PEND and during HELD on channel 2
      add(1'b0, 4'hB, 3,  4'h0, 4'h0, 4'h0);
      add(1'b1, 4'hB, 1,  4'h0, 4'h0, 4'h0);
      add(1'b0, 4'hB, 6,  4'h4, 4'h4, 4'h0);
      add(1'b0, 4'hB, 2,  4'h4, 4'h0, 4'h0);
      add(1'b1, 4'hB, 1,  4'h0, 4'h0, 4'h0);
      add(1'b0, 4'hB, 5,  4'h0, 4'h0, 4'h0);
      add(1'b0, 4'hB, 1,  4'h4, 4'h4, 4'h0);
      add(1'b0, 4'hF, 6,  4'h0, 4'h0, 4'h4);
      add(1'b0, 4'hF, 2,  4'h0, 4'h0, 4'h0);
      // long hold on channel 3 (auto-repeat points t0+10, t0+13)
      add(1'b0, 4'h7, 6,  4'h8, 4'h8, 4'h0);
      add(1'b0, 4'h7, 9,  4'h8, 4'h0, 4'h0);
      add(1'b0, 4'h7, 1,  4'h8, REP_P, 4'h0);
      add(1'b0, 4'h7, 2,  4'h8, 4'h0, 4'h0);
      add(1'b0, 4'h7, 1,  4'h8, REP_P, 4'h0);
      add(1'b0, 4'h7, 14, 4'h8, 4'h0, 4'h0);
      add(1'b0, 4'hF, 6,  4'h0, 4'h0, 4'h8);

      for (int i = 0; i < segs.size(); i++) begin
         for (int c = 0; c < segs[i].ncyc; c++)
            tick(segs[i].rst, segs[i].key);
         n_tests++;
         if (key_o !== segs[i].ek || press_o !== segs[i].ep || release_o !== segs[i].er) begin
            n_fail++;
            $display("FAIL seg%0d: key_o=%h press_o=%h release_o=%h, required %h %h %h",
                     i, key_o, press_o, release_o, segs[i].ek, segs[i].ep, segs[i].er);
         end
      end

      // hand sequence: release bounce during HELD restarts the repeat timing
      for (int c = 0; c < 6; c++) tick(1'b0, 4'h7);     // press accepted
      for (int c = 0; c < 4; c++) tick(1'b0, 4'h7);
      tick(1'b0, 4'hF);                                 // 2-cycle glitch
      tick(1'b0, 4'hF);
      for (int c = 0; c < 14; c++) tick(1'b0, 4'h7);
      n_tests++;
      if (key_o !== 4'h8 || release_o !== 4'h0) begin
         n_fail++;
         $display("FAIL glitch_hold: key_o=%h release_o=%h, required 8 0", key_o, release_o);
      end
      for (int c = 0; c < 8; c++) tick(1'b0, 4'hF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard bound in case the clocking ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
